data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 44 ++++
 rtl/data_mem_arbiter.sv | 114 +++++++++++
 tb/tb_data_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_arbiter_if                                            |
// | Brief   : Bundle of the two requester ports and the DataMemory port.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface data_mem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             p0_req, p0_we, p0_st_src, p0_ld_src;
    logic [WIDTH-1:0] p0_addr, p0_wdata;
    logic             p0_gnt, p0_rvalid;
    logic [WIDTH-1:0] p0_rdata;

    logic             p1_req, p1_we, p1_st_src, p1_ld_src, p1_lock;
    logic [WIDTH-1:0] p1_addr, p1_wdata;
    logic             p1_gnt, p1_rvalid;
    logic [WIDTH-1:0] p1_rdata;

    logic             mem_we, mem_st_src, mem_ld_src;
    logic [WIDTH-1:0] mem_addr, mem_wd;
    logic [WIDTH-1:0] mem_rd;

    // Requesters and memory side
    modport master (
        output p0_req, p0_we, p0_st_src, p0_ld_src, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_st_src, p1_ld_src, p1_lock, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_we, mem_st_src, mem_ld_src, mem_addr, mem_wd,
        output mem_rd
    );

    // Arbiter side
    modport slave (
        input  p0_req, p0_we, p0_st_src, p0_ld_src, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_st_src, p1_ld_src, p1_lock, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_we, mem_st_src, mem_ld_src, mem_addr, mem_wd,
        input  mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : data_mem_arbiter                                               |
// | Brief   : Two-port LRU arbiter with bounded port-1 lock for DataMemory.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_LOCK = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    data_mem_arbiter_if.slave bus
);
    localparam int              c_CW       = $clog2(MAX_LOCK + 1);
    localparam logic [c_CW-1:0] c_MAX_LOCK = c_CW'(MAX_LOCK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_ptr;          // 1: port 1 is the least recently granted
    logic [c_CW-1:0] r_lock_cnt, w_lock_cnt_nxt;
    logic            w_gnt0, w_gnt1, w_locked;

    logic             r_p0_rvalid, r_p1_rvalid;
    logic [WIDTH-1:0] r_p0_rdata, r_p1_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_gnt0)      r_ptr <= 1'b1;
            else if (w_gnt1) r_ptr <= 1'b0;
        end
    end

    always_comb begin
        w_gnt0         = 1'b0;
        w_gnt1         = 1'b0;
        w_locked       = 1'b0;
        w_state_nxt    = IDLE;
        w_lock_cnt_nxt = '0;
        if (rst_n) begin
            w_locked = (r_state == G1) && bus.p1_req && bus.p1_lock &&
                       (r_lock_cnt < c_MAX_LOCK);
            if (w_locked) begin
                w_gnt1 = 1'b1;
            end else if (bus.p0_req && bus.p1_req) begin
                w_gnt0 = ~r_ptr;
                w_gnt1 = r_ptr;
            end else begin
                w_gnt0 = bus.p0_req;
                w_gnt1 = bus.p1_req;
            end
        end
        if (w_gnt0)      w_state_nxt = G0;
        else if (w_gnt1) w_state_nxt = G1;
        // Unlocked port-1 grants hold the count, which saturates at MAX_LOCK
        if (w_gnt1) begin
            w_lock_cnt_nxt = w_locked ? r_lock_cnt + c_CW'(1) : r_lock_cnt;
        end
    end

    always_comb begin
        bus.mem_we     = 1'b0;
        bus.mem_st_src = 1'b0;
        bus.mem_ld_src = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wd     = '0;
        if (w_gnt0) begin
            bus.mem_we     = bus.p0_we;
            bus.mem_st_src = bus.p0_st_src;
            bus.mem_ld_src = bus.p0_ld_src;
            bus.mem_addr   = bus.p0_addr;
            bus.mem_wd     = bus.p0_wdata;
        end else if (w_gnt1) begin
            bus.mem_we     = bus.p1_we;
            bus.mem_st_src = bus.p1_st_src;
            bus.mem_ld_src = bus.p1_ld_src;
            bus.mem_addr   = bus.p1_addr;
            bus.mem_wd     = bus.p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt0 && !bus.p0_we;
            r_p1_rvalid <= w_gnt1 && !bus.p1_we;
            if (w_gnt0 && !bus.p0_we) r_p0_rdata <= bus.mem_rd;
            if (w_gnt1 && !bus.p1_we) r_p1_rdata <= bus.mem_rd;
        end
    end

    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.p0_rvalid = r_p0_rvalid;
    assign bus.p1_rvalid = r_p1_rvalid;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_data_mem_arbiter                                            |
// | Brief   : Directed and random checks of data_mem_arbiter vs a model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_arbiter;
    localparam int c_WIDTH    = 32;
    localparam int c_MAX_LOCK = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    data_mem_arbiter_if #(.WIDTH(c_WIDTH)) bus ();

    data_mem_arbiter #(.WIDTH(c_WIDTH), .MAX_LOCK(c_MAX_LOCK)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: timestamps of the last grant per port give the LRU order
    int          cyc;
    int          t0, t1;
    int          last_g;      // 0 none, 1 port 0, 2 port 1
    int          lk;
    logic        ev0, ev1;
    logic [31:0] ed0, ed1;
    int          dut_g;       // observed grant in the latest step

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t0 = cyc - 2;
        t1 = cyc - 1;
        last_g = 0;
        lk = 0;
        ev0 = 1'b0; ev1 = 1'b0;
        ed0 = '0;   ed1 = '0;
    endtask

    task automatic step();
        int   g;
        bit   locked;
        logic e_we, e_st, e_ld;
        logic [31:0] e_a, e_wd;
        @(negedge clk);
        locked = rst_n && last_g == 2 && bus.p1_req && bus.p1_lock && lk < c_MAX_LOCK;
        if (!rst_n)                     g = 0;
        else if (locked)                g = 2;
        else if (bus.p0_req && bus.p1_req) g = (t0 < t1) ? 1 : 2;
        else if (bus.p0_req)            g = 1;
        else if (bus.p1_req)            g = 2;
        else                            g = 0;
        e_we = 0; e_st = 0; e_ld = 0; e_a = '0; e_wd = '0;
        if (g == 1) begin
            e_we = bus.p0_we; e_st = bus.p0_st_src; e_ld = bus.p0_ld_src;
            e_a = bus.p0_addr; e_wd = bus.p0_wdata;
        end else if (g == 2) begin
            e_we = bus.p1_we; e_st = bus.p1_st_src; e_ld = bus.p1_ld_src;
            e_a = bus.p1_addr; e_wd = bus.p1_wdata;
        end
        dut_g = {30'd0, bus.p1_gnt, bus.p0_gnt};
        chk("p0_gnt", bus.p0_gnt, g == 1);
        chk("p1_gnt", bus.p1_gnt, g == 2);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_st_src", bus.mem_st_src, e_st);
        chk("mem_ld_src", bus.mem_ld_src, e_ld);
        chk("mem_addr", bus.mem_addr, e_a);
        chk("mem_wd", bus.mem_wd, e_wd);
        chk("p0_rvalid", bus.p0_rvalid, ev0);
        chk("p1_rvalid", bus.p1_rvalid, ev1);
        chk("p0_rdata", bus.p0_rdata, ed0);
        chk("p1_rdata", bus.p1_rdata, ed1);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            ev0 = (g == 1) && !bus.p0_we;
            ev1 = (g == 2) && !bus.p1_we;
            if (ev0) ed0 = bus.mem_rd;
            if (ev1) ed1 = bus.mem_rd;
            if (g != 2)      lk = 0;
            else if (locked) lk = lk + 1;
            if (g == 1) t0 = cyc;
            if (g == 2) t1 = cyc;
            last_g = g;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_st_src = 0; bus.p0_ld_src = 0;
        bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_st_src = 0; bus.p1_ld_src = 0;
        bus.p1_lock = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
    endtask

    initial begin
        cyc = 0;
        idle_inputs();
        bus.mem_rd = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Grants forced off while reset is low
        bus.p0_req = 1;
        step();
        chk("rst_gnt", dut_g, 0);
        rst_n = 1'b1;
        idle_inputs();

        // No requests: all quiet
        repeat (2) step();
        chk("idle_gnt", dut_g, 0);

        // p0 read of 0x10
        bus.p0_req = 1; bus.p0_addr = 32'h10; bus.mem_rd = 32'hDEADBEEF;
        step();
        chk("rd_gnt", dut_g, 1);
        chk("rd_rvalid", bus.p0_rvalid, 1'b1);
        chk("rd_rdata", bus.p0_rdata, 32'hDEADBEEF);
        idle_inputs();
        bus.mem_rd = 32'h1234_5678;
        step();

        // p0 byte-style store
        bus.p0_req = 1; bus.p0_we = 1; bus.p0_st_src = 1;
        bus.p0_addr = 32'h20; bus.p0_wdata = 32'hAA;
        step();
        chk("wr_gnt", dut_g, 1);
        chk("wr_rvalid", bus.p0_rvalid, 1'b0);
        chk("wr_rdata_hold", bus.p0_rdata, 32'hDEADBEEF);
        idle_inputs();

        // Contended reads alternate
        bus.p0_req = 1; bus.p1_req = 1;
        begin
            int prev;
            step();
            prev = dut_g;
            for (int i = 0; i < 6; i++) begin
                bus.mem_rd = $urandom;
                step();
                chk("alt_gnt", dut_g, (prev == 1) ? 2 : 1);
                prev = dut_g;
            end
        end

        // Lock: one p0 grant, then p1 first grant + MAX_LOCK locked, then p0
        bus.p1_req = 0;
        step();
        bus.p1_req = 1; bus.p1_lock = 1;
        step();
        chk("lock_first", dut_g, 2);
        for (int i = 0; i < c_MAX_LOCK; i++) begin
            step();
            chk("lock_held", dut_g, 2);
        end
        step();
        chk("lock_release", dut_g, 1);
        step();
        chk("lock_resume", dut_g, 2);
        idle_inputs();

        // Reset during a p1 write grant
        bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h44; bus.p1_wdata = 32'h55;
        step();
        rst_n = 1'b0;
        step();
        chk("rstwr_gnt", dut_g, 0);
        rst_n = 1'b1;
        idle_inputs();
        step();
        bus.p0_req = 1; bus.p1_req = 1;
        step();
        chk("post_rst_gnt", dut_g, 1);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rst_n         = ($urandom_range(0, 59) != 0);
            bus.p0_req    = ($urandom_range(0, 9) < 7);
            bus.p1_req    = ($urandom_range(0, 9) < 8);
            bus.p1_lock   = ($urandom_range(0, 9) < 8);
            bus.p0_we     = $urandom_range(0, 1);
            bus.p1_we     = $urandom_range(0, 1);
            bus.p0_st_src = $urandom_range(0, 1);
            bus.p0_ld_src = $urandom_range(0, 1);
            bus.p1_st_src = $urandom_range(0, 1);
            bus.p1_ld_src = $urandom_range(0, 1);
            bus.p0_addr   = $urandom;
            bus.p1_addr   = $urandom;
            bus.p0_wdata  = $urandom;
            bus.p1_wdata  = $urandom;
            bus.mem_rd    = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
